// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller: bus-mapped seven-segment controller, static or one-hot scanned drive.
// Latency: register writes reach the display outputs two edges after the strobe; reads are combinational.
// Backpressure: none, every i_en access completes in its own cycle.
//
// Ports:
//   clk, n_rst              clock, asynchronous active-low reset
//   i_en/i_rnw/i_addr/i_data single-cycle register access from the BIU slave
//   o_data/o_data_valid     read data, valid in the same cycle as a read strobe
//   o_hex/o_dp              static per-digit segments and decimal points (active-low)
//   o_seg/o_seg_dp/o_an     scanned segment bus, decimal point and one-hot anodes (active-low)
module seg7_scan_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    i_en,
  input  logic                    i_rnw,
  input  logic [2:0]              i_addr,
  input  logic [DATA_WIDTH-1:0]   i_data,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_data_valid,
  output logic [NUM_DIGITS*7-1:0] o_hex,
  output logic [NUM_DIGITS-1:0]   o_dp,
  output logic [6:0]              o_seg,
  output logic                    o_seg_dp,
  output logic [NUM_DIGITS-1:0]   o_an
);

  localparam int SCW  = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int BLW  = (BLINK_DIV > 1)  ? $clog2(BLINK_DIV)  : 1;
  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SCW-1:0]  SCAN_LAST  = SCW'(SCAN_DIV - 1);
  localparam logic [BLW-1:0]  BLINK_LAST = BLW'(BLINK_DIV - 1);
  localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(NUM_DIGITS - 1);

  localparam logic [2:0] ADDR_DATA_LO = 3'd0;
  localparam logic [2:0] ADDR_DATA_HI = 3'd1;
  localparam logic [2:0] ADDR_CTRL    = 3'd2;
  localparam logic [2:0] ADDR_BLANK   = 3'd3;
  localparam logic [2:0] ADDR_BLINK   = 3'd4;
  localparam logic [2:0] ADDR_DP      = 3'd5;

  // Register file
  logic [4*NUM_DIGITS-1:0] data_q;
  logic                    enable_q;
  logic                    mode_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic [NUM_DIGITS-1:0]   blink_q;
  logic [NUM_DIGITS-1:0]   dp_q;

  // Timebases
  logic [BLW-1:0]  blink_cnt;
  logic            blink_phase;
  logic [SCW-1:0]  scan_cnt;
  logic [IDXW-1:0] scan_idx;

  logic wr_en;
  logic ctrl_wr;
  logic scan_clr;

  assign wr_en   = i_en && !i_rnw;
  assign ctrl_wr = wr_en && (i_addr == ADDR_CTRL);
  // Leaving/entering scan mode or disabling restarts the scan from digit 0.
  assign scan_clr = ctrl_wr && ((i_data[1] != mode_q) || !i_data[0]);

  // Digit nibbles viewed as a full 16-digit image; absent digits read as zero.
  logic [63:0] data_ext;
  logic [63:0] data_wr;
  logic [31:0] blank_ext;
  logic [31:0] blink_ext;
  logic [31:0] dp_ext;

  always_comb begin
    data_ext = '0;
    data_ext[4*NUM_DIGITS-1:0] = data_q;
    blank_ext = '0;
    blank_ext[NUM_DIGITS-1:0] = blank_q;
    blink_ext = '0;
    blink_ext[NUM_DIGITS-1:0] = blink_q;
    dp_ext = '0;
    dp_ext[NUM_DIGITS-1:0] = dp_q;
    // A write to one data word must leave the other half of the image intact.
    if (i_addr == ADDR_DATA_HI) begin
      data_wr = {i_data[31:0], data_ext[31:0]};
    end else begin
      data_wr = {data_ext[63:32], i_data[31:0]};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_q   <= '0;
      enable_q <= 1'b1;
      mode_q   <= 1'b0;
      blank_q  <= '0;
      blink_q  <= '0;
      dp_q     <= '0;
    end else if (wr_en) begin
      case (i_addr)
        ADDR_DATA_LO, ADDR_DATA_HI: data_q <= data_wr[4*NUM_DIGITS-1:0];
        ADDR_CTRL: begin
          enable_q <= i_data[0];
          mode_q   <= i_data[1];
        end
        ADDR_BLANK: blank_q <= i_data[NUM_DIGITS-1:0];
        ADDR_BLINK: blink_q <= i_data[NUM_DIGITS-1:0];
        ADDR_DP:    dp_q    <= i_data[NUM_DIGITS-1:0];
        default: ;
      endcase
    end
  end

  // Blink timebase free-runs independent of ENABLE and MODE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Scan prescaler and digit index; held at zero unless actively scanning.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_clr || !(enable_q && mode_q)) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Read path
  logic [31:0] rd_data;

  always_comb begin
    rd_data = '0;
    case (i_addr)
      ADDR_DATA_LO: rd_data = data_ext[31:0];
      ADDR_DATA_HI: rd_data = data_ext[63:32];
      ADDR_CTRL:    rd_data = {30'd0, mode_q, enable_q};
      ADDR_BLANK:   rd_data = blank_ext;
      ADDR_BLINK:   rd_data = blink_ext;
      ADDR_DP:      rd_data = dp_ext;
      default:      rd_data = '0;
    endcase
  end

  assign o_data_valid = i_en && i_rnw;
  assign o_data       = o_data_valid ? rd_data : '0;

  // Active-low hex glyphs, bit0 = segment a .. bit6 = segment g.
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: hex_glyph = 7'b1000000;
      4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;
      4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;
      4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;
      4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;
      4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  // Per-digit glyph after the dark rule; padded to 16 so the scan index is always in range.
  logic [15:0][6:0] glyph;
  logic [15:0]      glyph_dp;

  always_comb begin
    glyph    = {16{7'h7F}};
    glyph_dp = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (enable_q && !blank_q[i] && !(blink_q[i] && blink_phase)) begin
        glyph[i]    = hex_glyph(data_q[4*i +: 4]);
        glyph_dp[i] = ~dp_q[i];
      end
    end
  end

  logic [NUM_DIGITS*7-1:0] hex_d;
  logic [NUM_DIGITS-1:0]   dp_d;
  logic [6:0]              seg_d;
  logic                    seg_dp_d;
  logic [NUM_DIGITS-1:0]   an_d;

  always_comb begin
    hex_d    = '1;
    dp_d     = '1;
    seg_d    = 7'h7F;
    seg_dp_d = 1'b1;
    an_d     = '1;
    if (enable_q && mode_q) begin
      seg_d    = glyph[4'(scan_idx)];
      seg_dp_d = glyph_dp[4'(scan_idx)];
      an_d     = ~(NUM_DIGITS'(1) << scan_idx);
    end else begin
      // Disabled also lands here; every glyph is already dark in that case.
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hex_d[7*i +: 7] = glyph[i];
        dp_d[i]         = glyph_dp[i];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_hex    <= '1;
      o_dp     <= '1;
      o_seg    <= 7'h7F;
      o_seg_dp <= 1'b1;
      o_an     <= '1;
    end else begin
      o_hex    <= hex_d;
      o_dp     <= dp_d;
      o_seg    <= seg_d;
      o_seg_dp <= seg_dp_d;
      o_an     <= an_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb_seg7_scan_controller: randomized register traffic against a time-based display model.
// Latency: model predicts outputs per edge from register shadow and elapsed-cycle arithmetic.
// Backpressure: none; one access per strobe.
module tb_seg7_scan_controller;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BD = 8;

  logic            clk = 1'b0;
  logic            n_rst;
  logic            i_en;
  logic            i_rnw;
  logic [2:0]      i_addr;
  logic [31:0]     i_data;
  logic [31:0]     o_data;
  logic            o_data_valid;
  logic [ND*7-1:0] o_hex;
  logic [ND-1:0]   o_dp;
  logic [6:0]      o_seg;
  logic            o_seg_dp;
  logic [ND-1:0]   o_an;

  always #5 clk = ~clk;

  seg7_scan_controller #(
    .DATA_WIDTH(32), .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD)
  ) dut (
    .clk(clk), .n_rst(n_rst), .i_en(i_en), .i_rnw(i_rnw), .i_addr(i_addr),
    .i_data(i_data), .o_data(o_data), .o_data_valid(o_data_valid),
    .o_hex(o_hex), .o_dp(o_dp), .o_seg(o_seg), .o_seg_dp(o_seg_dp), .o_an(o_an)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int         nib [16];
  bit         m_en, m_mode;
  bit [15:0]  m_blank, m_blink, m_dp;
  int         k;   // edges since reset release
  int         st;  // edges spent scanning since the last scan restart
  logic [ND*7-1:0] e_hex;
  logic [ND-1:0]   e_dp, e_an;
  logic [6:0]      e_seg;
  logic            e_sdp;
  bit              checking = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) nib[i] = 0;
    m_en = 1'b1; m_mode = 1'b0;
    m_blank = '0; m_blink = '0; m_dp = '0;
    k = 0; st = 0;
    e_hex = '1; e_dp = '1; e_an = '1; e_seg = 7'h7F; e_sdp = 1'b1;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] r;
    logic [31:0] mask;
    r = '0;
    mask = (32'd1 << ND) - 32'd1;
    case (a)
      3'd0: for (int i = 0; i < ND && i < 8; i++) r = r | (32'(nib[i]) << (4 * i));
      3'd1: for (int i = 8; i < ND; i++) r = r | (32'(nib[i]) << (4 * (i - 8)));
      3'd2: r = {30'd0, m_mode, m_en};
      3'd3: r = {16'd0, m_blank} & mask;
      3'd4: r = {16'd0, m_blink} & mask;
      3'd5: r = {16'd0, m_dp} & mask;
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      model_reset();
    end else begin : step
      int phase, idx;
      bit dark;
      logic [6:0] g;
      logic gd;
      phase = (k / BD) % 2;
      idx   = (st / SD) % ND;
      e_hex = '1; e_dp = '1; e_an = '1; e_seg = 7'h7F; e_sdp = 1'b1;
      for (int i = 0; i < ND; i++) begin
        dark = !m_en || m_blank[i] || (m_blink[i] && phase == 1);
        g  = dark ? 7'h7F : glyph_tab[nib[i]];
        gd = dark ? 1'b1 : !m_dp[i];
        if (m_en && m_mode) begin
          if (i == idx) begin
            e_seg = g; e_sdp = gd; e_an[i] = 1'b0;
          end
        end else begin
          e_hex[7*i +: 7] = g;
          e_dp[i] = gd;
        end
      end
      if (i_en && !i_rnw && i_addr == 3'd2 && (i_data[1] != m_mode || !i_data[0])) st = 0;
      else if (m_en && m_mode) st++;
      else st = 0;
      if (i_en && !i_rnw) begin
        case (i_addr)
          3'd0: for (int i = 0; i < ND && i < 8; i++) nib[i] = int'(i_data[4*i +: 4]);
          3'd1: for (int i = 8; i < ND; i++) nib[i] = int'(i_data[4*(i-8) +: 4]);
          3'd2: begin m_en = i_data[0]; m_mode = i_data[1]; end
          3'd3: m_blank = i_data[15:0];
          3'd4: m_blink = i_data[15:0];
          3'd5: m_dp    = i_data[15:0];
          default: ;
        endcase
      end
      k++;
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      check("hex", o_hex, e_hex);
      check("dp", o_dp, e_dp);
      check("seg", o_seg, e_seg);
      check("seg_dp", o_seg_dp, e_sdp);
      check("an", o_an, e_an);
      check("rd_valid", o_data_valid, i_en && i_rnw);
      check("rd_data", o_data, (i_en && i_rnw) ? model_read(i_addr) : 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    i_en = 1'b1; i_rnw = 1'b0; i_addr = a; i_data = d;
    @(posedge clk); #1;
    i_en = 1'b0; i_data = '0;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [31:0] d, output logic v);
    @(posedge clk); #1;
    i_en = 1'b1; i_rnw = 1'b1; i_addr = a;
    #1;
    d = o_data; v = o_data_valid;
    @(posedge clk); #1;
    i_en = 1'b0; i_rnw = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic        v;
    int          dark_cnt;
    bit          found;
    i_en = 1'b0; i_rnw = 1'b0; i_addr = '0; i_data = '0;
    n_rst = 1'b0;
    model_reset();
    checking = 1'b1;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;

    // Reset state: every digit "0", nothing scanned.
    wait_neg(1);
    check("reset_hex", o_hex, {ND{7'b1000000}});
    check("reset_dp", o_dp, 4'hF);
    check("reset_an", o_an, 4'hF);
    do_read(3'd2, rd, v);
    check("reset_ctrl", rd, 32'h1);
    check("reset_ctrl_vld", v, 1'b1);

    // Static data write.
    do_write(3'd0, 32'h76543210);
    wait_neg(1);
    check("static_d0", o_hex[6:0], 7'b1000000);
    check("static_d1", o_hex[13:7], 7'b1111001);
    check("static_d3", o_hex[27:21], 7'b0110000);
    do_read(3'd0, rd, v);
    check("rd_data_lo", rd, 32'h00003210);

    // Unstored digits and mask bits, unused offsets.
    do_write(3'd1, 32'hFFFFFFFF);
    do_read(3'd1, rd, v);
    check("rd_data_hi", rd, 32'h0);
    do_write(3'd6, 32'h12345678);
    do_read(3'd6, rd, v);
    check("rd_off6", rd, 32'h0);
    do_write(3'd3, 32'h0000FFFF);
    do_read(3'd3, rd, v);
    check("rd_blank", rd, 32'hF);

    // Blank, dp and blink in static mode.
    do_write(3'd3, 32'h2);
    do_write(3'd5, 32'h4);
    do_write(3'd4, 32'h1);
    wait_neg(1);
    check("blank_d1", o_hex[13:7], 7'h7F);
    check("dp2_on", o_dp, 4'b1011);
    dark_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (o_hex[6:0] == 7'h7F) dark_cnt++;
      wait_neg(0);
      @(negedge clk);
    end
    check("blink_half_dark", dark_cnt, 8);
    do_write(3'd4, 32'h0);
    do_write(3'd3, 32'h0);
    do_write(3'd5, 32'h0);

    // Scan sequence: each anode held SD cycles.
    do_write(3'd0, 32'h0000A581);
    do_write(3'd2, 32'h3);
    wait_neg(1);
    check("scan_an0", o_an, 4'b1110);
    check("scan_seg0", o_seg, 7'b1111001);
    check("scan_hex_dark", o_hex, {ND{7'h7F}});
    wait_neg(4);
    check("scan_an1", o_an, 4'b1101);
    check("scan_seg1", o_seg, 7'b0000000);
    wait_neg(4);
    check("scan_an2", o_an, 4'b1011);
    wait_neg(4);
    check("scan_an3", o_an, 4'b0111);
    check("scan_seg3", o_seg, 7'b0001000);
    wait_neg(4);
    check("scan_an_wrap", o_an, 4'b1110);

    // Randomized register traffic.
    for (int n = 0; n < 600; n++) begin
      logic [2:0]  a;
      logic [31:0] d;
      repeat ($urandom_range(0, 6)) @(posedge clk);
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd2) d[0] = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) < 7) do_write(a, d);
      else do_read(a, rd, v);
    end

    // Reset in the middle of a scan at index 2.
    do_write(3'd0, 32'h00004321);
    do_write(3'd3, 32'h0);
    do_write(3'd4, 32'h0);
    do_write(3'd2, 32'h0);
    do_write(3'd2, 32'h3);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (o_an == 4'b1011) found = 1'b1;
    end
    check("reach_idx2", found, 1'b1);
    #2 n_rst = 1'b0;
    #1;
    check("arst_hex", o_hex, {ND{7'h7F}});
    check("arst_an", o_an, 4'hF);
    check("arst_seg", {o_seg, o_seg_dp}, 8'hFF);
    check("arst_dp", o_dp, 4'hF);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    wait_neg(1);
    check("post_rst_hex", o_hex, {ND{7'b1000000}});
    check("post_rst_an", o_an, 4'hF);
    do_read(3'd2, rd, v);
    check("post_rst_ctrl", rd, 32'h1);
    wait_neg(2);

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
